cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//   Run sequencer for the 8-bit stack CPU. On start it copies the program from a sync program ROM
//   into CPU memory through the memory write port, then seeds the I/O cells (x, error, result).
//   It then releases the CPU with a clock enable, one instruction per enabled cycle.
//   It stops the CPU on a halt PC or a watchdog timeout; optional single-step mode for debug.
// PARAMETERS
//   PROG_LEN   37   number of program bytes copied, ROM addresses 0..PROG_LEN-1
//   HALT_PC    37   PC value that marks normal program end
//   MAX_INSTR  255  watchdog limit on executed instructions, 1..65535
//   X_ADDR     255  memory cell seeded with x
//   ERR_ADDR   253  memory cell cleared before run
//   RES_ADDR   254  memory cell cleared before run
// PORTS
//   clock        in   1   single system clock, all logic on posedge
//   reset        in   1   synchronous, active-high
//   start        in   1   1-cycle pulse, begin load+run; honoured only in IDLE/DONE/FAULT
//   x            in   8   operand, sampled on the accepted start cycle
//   step_en      in   1   1 = single-step mode during RUN
//   step         in   1   1-cycle pulse, release one instruction when step_en=1
//   prog_addr    out  8   program ROM read address; ROM data returns 1 cycle later
//   prog_data    in   8   program ROM read data
//   mem_we       out  1   CPU memory write strobe
//   mem_addr     out  8   CPU memory write address
//   mem_wdata    out  8   CPU memory write data
//   cpu_pc       in   8   current CPU program counter
//   cpu_hold     out  1   1 = CPU held in init (pc=0, sp=0, flags=0)
//   cpu_ce       out  1   CPU clock enable, one instruction per high cycle
//   busy         out  1   high in LOAD, SEED and RUN
//   done         out  1   level, program reached HALT_PC
//   timeout      out  1   level, watchdog expired
//   instr_count  out  16  instructions executed in the current run
// BEHAVIOUR
//   Reset: state=IDLE; cpu_hold=1; cpu_ce=0; mem_we=0; prog_addr=0; mem_addr=0; mem_wdata=0;
//     busy=0; done=0; timeout=0; instr_count=0. Reset mid-operation aborts with no further writes.
//   States: IDLE -> LOAD -> SEED -> RUN -> DONE | FAULT. DONE/FAULT -> LOAD on start.
//   Accepted start: latch x, clear done/timeout/instr_count, set cpu_hold=1, enter LOAD.
//   Start in LOAD/SEED/RUN is ignored.
//   LOAD: PROG_LEN+1 cycles.
//     Cycle j (0..PROG_LEN-1) drives prog_addr=j.
//     Cycle j+1 drives mem_we=1, mem_addr=j, mem_wdata=prog_data.
//     No write in the first LOAD cycle. Enter SEED after the write of address PROG_LEN-1.
//   SEED: 3 cycles, mem_we=1 each cycle: X_ADDR<-x_latched, ERR_ADDR<-0, RES_ADDR<-0.
//     Then cpu_hold=0 and enter RUN. mem_we=0 in all other states.
//   RUN, step_en=0: cpu_ce=1 every cycle.
//   RUN, step_en=1: cpu_ce=1 for exactly one cycle after each step pulse.
//     A step arriving while cpu_ce is already high for a prior step is dropped.
//   instr_count increments on every cycle with cpu_ce=1; it saturates and does not wrap.
//   Halt: when cpu_pc==HALT_PC is sampled in RUN, the next cycle has cpu_ce=0, state=DONE, done=1.
//   Watchdog: when instr_count==MAX_INSTR and halt is not seen, the next cycle has cpu_ce=0,
//     state=FAULT, timeout=1.
//   Halt and watchdog in the same cycle: halt wins (DONE).
//   step_en changes take effect on the next cycle. cpu_ce never asserts outside RUN.
//   DONE/FAULT: busy=0; cpu_hold=0 so the CPU memory stays readable; done/timeout held until start/reset.
// TESTING
//   reset, start with x=10: 37 writes to addrs 0..36 in order, then 255<-10, 253<-0, 254<-0
//     -> RUN, done=1, timeout=0, instr_count=20.
//   MAX_INSTR=8, x=10 -> FAULT, timeout=1, done=0, instr_count=8, cpu_ce low after 8th.
//   step_en=1, three step pulses 5 cycles apart -> exactly 3 single-cycle cpu_ce pulses, instr_count=3.
//   reset asserted in LOAD cycle 10 -> mem_we=0 next cycle, IDLE; a new start reloads from addr 0.
//   start pulsed mid-RUN -> ignored, run completes as before.
//   start again from DONE -> done cleared, instr_count=0, full reload.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the 8-bit stack CPU: copies the program ROM into CPU memory, seeds the
// I/O cells, then clocks the CPU (free-running or single-step) until halt PC or watchdog.
module cpu_run_ctrl #(
  parameter int PROG_LEN  = 37,
  parameter int HALT_PC   = 37,
  parameter int MAX_INSTR = 255,
  parameter int X_ADDR    = 255,
  parameter int ERR_ADDR  = 253,
  parameter int RES_ADDR  = 254
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic        step_en,
  input  logic        step,
  output logic [7:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  cpu_pc,
  output logic        cpu_hold,
  output logic        cpu_ce,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] instr_count,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEED  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [7:0]  LOAD_LAST = 8'(PROG_LEN);
  localparam logic [7:0]  HALT_B    = 8'(HALT_PC);
  localparam logic [15:0] MAX_B     = 16'(MAX_INSTR);
  localparam logic [7:0]  X_B       = 8'(X_ADDR);
  localparam logic [7:0]  ERR_B     = 8'(ERR_ADDR);
  localparam logic [7:0]  RES_B     = 8'(RES_ADDR);

  logic [2:0] state;
  logic [7:0] load_cnt;
  logic [1:0] seed_cnt;
  logic [7:0] x_q;
  logic       step_mode_q;
  logic       step_pend_q;
  logic       halt_hit;
  logic       wd_hit;
  logic       can_start;

  assign halt_hit  = (cpu_pc == HALT_B);
  assign wd_hit    = (instr_count == MAX_B);
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      load_cnt    <= 8'd0;
      seed_cnt    <= 2'd0;
      x_q         <= 8'd0;
      instr_count <= 16'd0;
      step_mode_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_mode_q <= step_en;
      // A step seen while the previous step's enable is still high is dropped.
      step_pend_q <= (state == S_RUN) && step_en && step && !step_pend_q;
      if (cpu_ce && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 16'd1;
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            x_q         <= x;
            instr_count <= 16'd0;
            load_cnt    <= 8'd0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_cnt == LOAD_LAST) begin
            seed_cnt <= 2'd0;
            state    <= S_SEED;
          end else begin
            load_cnt <= load_cnt + 8'd1;
          end
        end
        S_SEED: begin
          if (seed_cnt == 2'd2) state <= S_RUN;
          else seed_cnt <= seed_cnt + 2'd1;
        end
        S_RUN: begin
          if (halt_hit) state <= S_DONE;
          else if (wd_hit) state <= S_FAULT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ROM data for address j arrives in LOAD cycle j+1 and is written straight through.
  always_comb begin
    prog_addr = 8'd0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    if (state == S_LOAD) begin
      if (load_cnt < LOAD_LAST) prog_addr = load_cnt;
      if (load_cnt != 8'd0) begin
        mem_we    = 1'b1;
        mem_addr  = load_cnt - 8'd1;
        mem_wdata = prog_data;
      end
    end else if (state == S_SEED) begin
      mem_we = 1'b1;
      case (seed_cnt)
        2'd0:    begin mem_addr = X_B;   mem_wdata = x_q;  end
        2'd1:    begin mem_addr = ERR_B; mem_wdata = 8'd0; end
        default: begin mem_addr = RES_B; mem_wdata = 8'd0; end
      endcase
    end
  end

  // Halt PC and watchdog gate the enable in the same cycle they are seen.
  assign cpu_ce = (state == S_RUN) && !halt_hit && !wd_hit &&
                  (step_mode_q ? step_pend_q : 1'b1);

  assign cpu_hold  = (state == S_IDLE) || (state == S_LOAD) || (state == S_SEED);
  assign busy      = (state == S_LOAD) || (state == S_SEED) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign timeout   = (state == S_FAULT);
  assign dbg_state = state;

endmodule
